// File: rtl/pika_ai_ctrl.sv
// Computer opponent for the left-side Pikachu.
// Watches the ball and its own player, and produces a button vector with the
// same bit layout as the human usr_btn bus: {0, left, jump, right}.
// Horizontal presses are re-decided on a slow periodic tick; jumps are held
// long enough to pass the player's debouncer and are followed by a cooldown.
module pika_ai_ctrl #(
    parameter int unsigned DECIDE_PERIOD = 1_000_000,
    parameter int unsigned JUMP_HOLD     = 2_000_000,
    parameter int unsigned COOLDOWN      = 30_000_000,
    parameter int unsigned PLAYER_W      = 41,
    parameter int unsigned NET_X         = 160,
    parameter int unsigned GROUND_Y      = 177,
    parameter int unsigned HOME_X        = 60,
    parameter int unsigned DEADBAND      = 4,
    parameter int unsigned JUMP_WIN      = 12,
    parameter int unsigned JUMP_Y        = 110,
    parameter logic [1:0]  PLAY_STATE    = 2'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  game_state,
    input  logic [11:0] ball_x,
    input  logic [11:0] ball_y,
    input  logic        ball_dir,
    input  logic [11:0] ai_x,
    input  logic [11:0] ai_y,
    output logic [3:0]  ai_btn,
    output logic [1:0]  ai_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        JUMP  = 2'd2,
        COOL  = 2'd3
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(DECIDE_PERIOD - 1);
    localparam logic [31:0] HOLD_LAST = 32'(JUMP_HOLD - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOLDOWN - 1);

    localparam logic signed [12:0] HALF_W     = 13'(PLAYER_W / 2);
    localparam logic signed [12:0] CLAMP_LO   = HALF_W;
    localparam logic signed [12:0] CLAMP_HI   = 13'(NET_X - PLAYER_W + PLAYER_W / 2);
    localparam logic signed [12:0] HOME_S     = 13'(HOME_X);
    localparam logic signed [12:0] DEADBAND_S = 13'(DEADBAND);
    localparam logic signed [12:0] JUMP_WIN_S = 13'(JUMP_WIN);
    localparam logic [11:0]        JUMP_Y_V   = 12'(JUMP_Y);
    localparam logic [11:0]        GROUND_Y_V = 12'(GROUND_Y);

    state_t      state;
    logic [31:0] tick_cnt;
    logic [31:0] hold_cnt;
    logic [31:0] cool_cnt;
    logic        right_q;
    logic        jump_q;
    logic        left_q;

    logic               active;
    logic               tick;
    logic               jump_go;
    logic signed [12:0] center;
    logic signed [12:0] target_raw;
    logic signed [12:0] target;
    logic signed [12:0] err;
    logic signed [12:0] abs_err;

    assign active = enable && (game_state == PLAY_STATE);
    assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);

    // Chase the ball while it is coming over, otherwise drift back home;
    // the aim point is kept where the sprite can actually be on our half.
    always_comb begin
        center     = $signed({1'b0, ai_x}) + HALF_W;
        target_raw = ball_dir ? $signed({1'b0, ball_x}) : HOME_S;
        if (target_raw < CLAMP_LO)
            target = CLAMP_LO;
        else if (target_raw > CLAMP_HI)
            target = CLAMP_HI;
        else
            target = target_raw;
        err     = target - center;
        abs_err = (err < 0) ? -err : err;
        jump_go = ball_dir && (abs_err <= JUMP_WIN_S) &&
                  (ball_y >= JUMP_Y_V) && (ai_y == GROUND_Y_V);
    end

    // Control FSM: tick timing, horizontal decisions and the jump/cooldown sequence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            hold_cnt <= '0;
            cool_cnt <= '0;
            right_q  <= 1'b0;
            jump_q   <= 1'b0;
            left_q   <= 1'b0;
        end else if (!active) begin
            state    <= IDLE;
            tick_cnt <= '0;
            hold_cnt <= '0;
            cool_cnt <= '0;
            right_q  <= 1'b0;
            jump_q   <= 1'b0;
            left_q   <= 1'b0;
        end else begin
            if (state != IDLE) begin
                tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
                if (tick) begin
                    right_q <= (err > DEADBAND_S);
                    left_q  <= (err < -DEADBAND_S);
                end
            end
            case (state)
                IDLE: begin
                    state    <= TRACK;
                    tick_cnt <= '0;
                end
                TRACK: begin
                    if (jump_go) begin
                        state    <= JUMP;
                        jump_q   <= 1'b1;
                        hold_cnt <= HOLD_LAST;
                    end
                end
                JUMP: begin
                    if (hold_cnt == '0) begin
                        state    <= COOL;
                        jump_q   <= 1'b0;
                        cool_cnt <= COOL_LAST;
                    end else begin
                        hold_cnt <= hold_cnt - 32'd1;
                    end
                end
                COOL: begin
                    if (cool_cnt == '0)
                        state <= TRACK;
                    else
                        cool_cnt <= cool_cnt - 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ai_btn   = {1'b0, left_q, jump_q, right_q};
    assign ai_state = state;

endmodule

// File: tb/tb_pika_ai_ctrl.sv
// Directed testbench for pika_ai_ctrl with shortened timing parameters.
module tb_pika_ai_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [1:0]  game_state;
    logic [11:0] ball_x;
    logic [11:0] ball_y;
    logic        ball_dir;
    logic [11:0] ai_x;
    logic [11:0] ai_y;
    logic [3:0]  ai_btn;
    logic [1:0]  ai_state;

    int tests;
    int failed;

    pika_ai_ctrl #(
        .DECIDE_PERIOD(4),
        .JUMP_HOLD(8),
        .COOLDOWN(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .game_state(game_state),
        .ball_x(ball_x),
        .ball_y(ball_y),
        .ball_dir(ball_dir),
        .ai_x(ai_x),
        .ai_y(ai_y),
        .ai_btn(ai_btn),
        .ai_state(ai_state)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, settling 1 ns past each edge
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Force IDLE for one edge, then re-enter TRACK; afterwards the tick counter is 0
    task automatic enter_track();
        enable = 1'b0;
        cyc(1);
        enable = 1'b1;
        cyc(1);
    endtask

    task automatic set_track_right();
        ai_x = 12'd20; ai_y = 12'd177; ball_x = 12'd100; ball_y = 12'd50; ball_dir = 1'b1;
    endtask

    task automatic set_jump();
        ai_x = 12'd60; ai_y = 12'd177; ball_x = 12'd85; ball_y = 12'd120; ball_dir = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1; game_state = 2'd2; reset_n = 1'b0;
        set_track_right();
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            tests++;
            if (ai_btn !== 4'b0000 || ai_state !== 2'd0) begin
                failed++;
                $display("[TB] FAIL reset cyc%0d: btn=%b state=%0d, need btn=0000 state=0", i, ai_btn, ai_state);
            end
        end
        reset_n = 1'b1;
        cyc(1);
        tests++;
        if (ai_state !== 2'd1 || ai_btn !== 4'b0000) begin
            failed++;
            $display("[TB] FAIL reset_release: btn=%b state=%0d, need btn=0000 state=1", ai_btn, ai_state);
        end
    endtask

    task automatic test_track_right();
        set_track_right();
        enter_track();
        for (int i = 1; i <= 7; i++) begin
            logic [3:0] exp;
            cyc(1);
            exp = (i >= 4) ? 4'b0001 : 4'b0000;
            tests++;
            if (ai_btn !== exp || ai_state !== 2'd1) begin
                failed++;
                $display("[TB] FAIL track_right cyc%0d: btn=%b state=%0d, need btn=%b state=1", i, ai_btn, ai_state, exp);
            end
        end
    endtask

    task automatic test_home_clamp_deadband();
        logic [11:0] xs   [6];
        logic [11:0] bxs  [6];
        logic        dirs [6];
        logic [3:0]  exps [6];
        // home left, deadband +2, err +5, err +4, err -5, clamp high err 0
        xs   = '{12'd100, 12'd38, 12'd35, 12'd36, 12'd45, 12'd119};
        bxs  = '{12'd0,   12'd0,  12'd0,  12'd0,  12'd0,  12'd300};
        dirs = '{1'b0,    1'b0,   1'b0,   1'b0,   1'b0,   1'b1};
        exps = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        ai_y = 12'd177; ball_y = 12'd50;
        ai_x = xs[0]; ball_x = bxs[0]; ball_dir = dirs[0];
        enter_track();
        for (int i = 0; i < 6; i++) begin
            ai_x = xs[i]; ball_x = bxs[i]; ball_dir = dirs[i];
            cyc(4);
            tests++;
            if (ai_btn !== exps[i]) begin
                failed++;
                $display("[TB] FAIL home_clamp step%0d: btn=%b, need %b", i, ai_btn, exps[i]);
            end
        end
    endtask

    task automatic test_jump();
        set_jump();
        enter_track();
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc(1);
            tests++;
            if (ai_btn[1] !== 1'b1 || ai_state !== 2'd2) begin
                failed++;
                $display("[TB] FAIL jump_hold cyc%0d: btn=%b state=%0d, need jump=1 state=2", i, ai_btn, ai_state);
            end
        end
        tests++;
        if (ai_btn !== 4'b0011) begin
            failed++;
            $display("[TB] FAIL jump_with_right: btn=%b, need 0011", ai_btn);
        end
        cyc(1);
        tests++;
        if (ai_btn[1] !== 1'b0 || ai_state !== 2'd3) begin
            failed++;
            $display("[TB] FAIL jump_release: btn=%b state=%0d, need jump=0 state=3", ai_btn, ai_state);
        end
        for (int i = 1; i < 16; i++) begin
            cyc(1);
            tests++;
            if (ai_state !== 2'd3 || ai_btn[1] !== 1'b0) begin
                failed++;
                $display("[TB] FAIL cooldown cyc%0d: btn=%b state=%0d, need jump=0 state=3", i, ai_btn, ai_state);
            end
        end
        cyc(1);
        tests++;
        if (ai_state !== 2'd1 || ai_btn[1] !== 1'b0) begin
            failed++;
            $display("[TB] FAIL cool_exit: btn=%b state=%0d, need jump=0 state=1", ai_btn, ai_state);
        end
        cyc(1);
        tests++;
        if (ai_state !== 2'd2 || ai_btn[1] !== 1'b1) begin
            failed++;
            $display("[TB] FAIL second_jump: btn=%b state=%0d, need jump=1 state=2", ai_btn, ai_state);
        end
    endtask

    task automatic test_abort();
        set_jump();
        enter_track();
        cyc(3);
        tests++;
        if (ai_state !== 2'd2 || ai_btn !== 4'b0010) begin
            failed++;
            $display("[TB] FAIL abort_pre: btn=%b state=%0d, need btn=0010 state=2", ai_btn, ai_state);
        end
        game_state = 2'd1;
        cyc(1);
        tests++;
        if (ai_state !== 2'd0 || ai_btn !== 4'b0000) begin
            failed++;
            $display("[TB] FAIL abort_edge: btn=%b state=%0d, need btn=0000 state=0", ai_btn, ai_state);
        end
        set_track_right();
        game_state = 2'd2;
        cyc(1);
        tests++;
        if (ai_state !== 2'd1 || ai_btn !== 4'b0000) begin
            failed++;
            $display("[TB] FAIL abort_reenter: btn=%b state=%0d, need btn=0000 state=1", ai_btn, ai_state);
        end
        cyc(3);
        tests++;
        if (ai_btn !== 4'b0000) begin
            failed++;
            $display("[TB] FAIL abort_pretick: btn=%b, need 0000", ai_btn);
        end
        cyc(1);
        tests++;
        if (ai_btn !== 4'b0001) begin
            failed++;
            $display("[TB] FAIL abort_first_tick: btn=%b, need 0001", ai_btn);
        end
    endtask

    task automatic test_jump_blocked();
        for (int s = 0; s < 2; s++) begin
            int seen;
            set_jump();
            if (s == 0) ai_y = 12'd150;
            else        ball_y = 12'd100;
            enter_track();
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                cyc(1);
                if (ai_btn[1] === 1'b1 || ai_state !== 2'd1) seen++;
            end
            tests++;
            if (seen != 0) begin
                failed++;
                $display("[TB] FAIL jump_blocked case%0d: %0d bad cycles, need 0", s, seen);
            end
        end
    endtask

    task automatic test_jump_bounds();
        // ball_y exactly at threshold with err exactly at window edge: jumps
        set_jump();
        ball_y = 12'd110; ball_x = 12'd92;
        enter_track();
        cyc(1);
        tests++;
        if (ai_state !== 2'd2 || ai_btn[1] !== 1'b1) begin
            failed++;
            $display("[TB] FAIL jump_edge_ok: btn=%b state=%0d, need jump=1 state=2", ai_btn, ai_state);
        end
        // err of 13 is just outside the window: stays in TRACK
        set_jump();
        ball_x = 12'd93;
        enter_track();
        cyc(3);
        tests++;
        if (ai_state !== 2'd1 || ai_btn[1] !== 1'b0) begin
            failed++;
            $display("[TB] FAIL jump_edge_out: btn=%b state=%0d, need jump=0 state=1", ai_btn, ai_state);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset_n = 1'b0; enable = 1'b0; game_state = 2'd0;
        ball_x = '0; ball_y = '0; ball_dir = 1'b0; ai_x = '0; ai_y = '0;
        test_reset();
        test_track_right();
        test_home_clamp_deadband();
        test_jump();
        test_abort();
        test_jump_blocked();
        test_jump_bounds();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
